// File: rtl/nat_conn_table_pkg.sv
// Shared definitions for the NAT connection table: tuple field offsets, FSM encoding, hash fold.
// The fold XORs the low byte of every field, so it is independent of field order.
package nat_pkg;
  localparam int TUPLE_BITS = 104;

  localparam int F_PROTO   = 0;
  localparam int F_PORT_LO = 8;
  localparam int F_PORT_HI = 24;
  localparam int F_IP_LO   = 40;
  localparam int F_IP_HI   = 72;

  localparam int TX_OUTER_PORT = F_PORT_LO;
  localparam int TX_INNER_PORT = F_PORT_HI;
  localparam int TX_OUTER_IP   = F_IP_LO;
  localparam int TX_INNER_IP   = F_IP_HI;

  localparam int RX_NAT_PORT   = F_PORT_LO;
  localparam int RX_OUTER_PORT = F_PORT_HI;
  localparam int RX_INNER_IP   = F_IP_LO;
  localparam int RX_OUTER_IP   = F_IP_HI;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TX_PROBE = 2'd1;
  localparam logic [1:0] ST_RX_PROBE = 2'd2;
  localparam logic [1:0] ST_RX_INS   = 2'd3;

  // Callers keep the low HASH_LEN bits; HASH_LEN never exceeds 8.
  function automatic logic [7:0] nat_hash8(input logic [TUPLE_BITS-1:0] k);
    return k[F_PROTO +: 8] ^ k[F_PORT_LO +: 8] ^ k[F_PORT_HI +: 8]
         ^ k[F_IP_LO +: 8] ^ k[F_IP_HI +: 8];
  endfunction
endpackage

// File: rtl/nat_conn_table_if.sv
// Request/response bundle between the tuple extractor, the NAT table and the header rewriter.
interface nat_conn_table_if #(
  parameter int HASH_LEN = 6,
  parameter int TUPLE_W  = 104
);
  logic [TUPLE_W-1:0] tuple_data_0;
  logic               tuple_valid_0;
  logic               tuple_ready_0;
  logic [15:0]        conn_data_0;
  logic               conn_valid_0;
  logic               conn_miss_0;
  logic [TUPLE_W-1:0] tuple_data_1;
  logic               tuple_valid_1;
  logic               tuple_ready_1;
  logic [15:0]        conn_data_1;
  logic               conn_valid_1;
  logic               conn_miss_1;
  logic               table_full;
  logic [HASH_LEN:0]  conn_count;

  modport master (
    output tuple_data_0, tuple_valid_0, tuple_data_1, tuple_valid_1,
    input  tuple_ready_0, conn_data_0, conn_valid_0, conn_miss_0,
    input  tuple_ready_1, conn_data_1, conn_valid_1, conn_miss_1,
    input  table_full, conn_count
  );

  modport slave (
    input  tuple_data_0, tuple_valid_0, tuple_data_1, tuple_valid_1,
    output tuple_ready_0, conn_data_0, conn_valid_0, conn_miss_0,
    output tuple_ready_1, conn_data_1, conn_valid_1, conn_miss_1,
    output table_full, conn_count
  );
endinterface

// File: rtl/nat_probe_table.sv
// One hash bucket array: valid bits (reset), key/value storage (not reset), single-slot compare.
// Read is combinational on rd_idx; a write lands on the next rising edge.
module nat_probe_table #(
  parameter int KEY_W = 104,
  parameter int VAL_W = 16,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [KEY_W-1:0] rd_key,
  output logic             rd_vld,
  output logic             rd_hit,
  output logic [VAL_W-1:0] rd_val,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [VAL_W-1:0] wr_val
);
  localparam int DEPTH = 2**IDX_W;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [KEY_W-1:0] key_mem [DEPTH];
  logic [VAL_W-1:0] val_mem [DEPTH];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_idx] <= wr_key;
      val_mem[wr_idx] <= wr_val;
    end
  end

  assign rd_vld = valid_q[rd_idx];
  assign rd_hit = rd_vld && (key_mem[rd_idx] == rd_key);
  assign rd_val = val_mem[rd_idx];
endmodule

// File: rtl/nat_conn_table.sv
// NAT connection table: tx allocates/looks up a connection ID, rx maps a reply back to the inner port.
// One request in flight; linear probing bounded by MAX_PROBE; round-robin grant between channels.
module nat_conn_table
  import nat_pkg::*;
#(
  parameter int HASH_LEN  = 6,
  parameter int TUPLE_W   = TUPLE_BITS,
  parameter int MAX_PROBE = 2**HASH_LEN
) (
  input logic             clk,
  input logic             reset,
  nat_conn_table_if.slave bus
);
  localparam int DEPTH = 2**HASH_LEN;
  localparam int CW    = HASH_LEN + 1;
  localparam logic [CW-1:0] PROBE_LAST = CW'(MAX_PROBE - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  logic [1:0]          state_q, state_d;
  logic [TUPLE_W-1:0]  key_q, key_d;
  logic [HASH_LEN-1:0] loc_q, loc_d;
  logic [CW-1:0]       probe_cnt_q, probe_cnt_d;
  logic [CW-1:0]       next_id_q, next_id_d;
  logic [CW-1:0]       conn_count_q, conn_count_d;
  logic                rr_q, rr_d;
  logic [15:0]         data0_q, data0_d, data1_q, data1_d;
  logic                vld0_q, vld0_d, miss0_q, miss0_d;
  logic                vld1_q, vld1_d, miss1_q, miss1_d;

  logic grant0, grant1, full, tx_wr, rx_wr;
  logic tx_vld, tx_hit, rx_vld, rx_hit;
  logic [HASH_LEN-1:0] tx_val;
  logic [15:0]         rx_val;
  logic [TUPLE_W-1:0]  rx_key;

  function automatic logic [HASH_LEN-1:0] hidx(input logic [TUPLE_BITS-1:0] k);
    logic [7:0] f;
    f = nat_hash8(k);
    return f[HASH_LEN-1:0];
  endfunction

  // Reverse-direction key for the connection being allocated: nat_port carries the new ID.
  always_comb begin
    rx_key = '0;
    rx_key[RX_OUTER_IP   +: 32] = key_q[TX_OUTER_IP   +: 32];
    rx_key[RX_INNER_IP   +: 32] = key_q[TX_INNER_IP   +: 32];
    rx_key[RX_OUTER_PORT +: 16] = key_q[TX_OUTER_PORT +: 16];
    rx_key[RX_NAT_PORT   +: 16] = 16'(next_id_q);
    rx_key[F_PROTO       +: 8]  = key_q[F_PROTO       +: 8];
  end

  assign full   = (conn_count_q == FULL_CNT);
  assign grant0 = bus.tuple_valid_0 && (!bus.tuple_valid_1 || !rr_q);
  assign grant1 = bus.tuple_valid_1 && (!bus.tuple_valid_0 ||  rr_q);
  assign bus.tuple_ready_0 = (state_q == ST_IDLE) && grant0;
  assign bus.tuple_ready_1 = (state_q == ST_IDLE) && grant1;

  nat_probe_table #(.KEY_W(TUPLE_W), .VAL_W(HASH_LEN), .IDX_W(HASH_LEN)) u_tx_tbl (
    .clk(clk), .rst(reset), .rd_idx(loc_q), .rd_key(key_q),
    .rd_vld(tx_vld), .rd_hit(tx_hit), .rd_val(tx_val),
    .wr_en(tx_wr), .wr_idx(loc_q), .wr_key(key_q), .wr_val(next_id_q[HASH_LEN-1:0])
  );

  nat_probe_table #(.KEY_W(TUPLE_W), .VAL_W(16), .IDX_W(HASH_LEN)) u_rx_tbl (
    .clk(clk), .rst(reset), .rd_idx(loc_q), .rd_key(key_q),
    .rd_vld(rx_vld), .rd_hit(rx_hit), .rd_val(rx_val),
    .wr_en(rx_wr), .wr_idx(loc_q), .wr_key(rx_key), .wr_val(key_q[TX_INNER_PORT +: 16])
  );

  always_comb begin
    state_d = state_q;  key_d = key_q;  loc_d = loc_q;  probe_cnt_d = probe_cnt_q;
    next_id_d = next_id_q;  conn_count_d = conn_count_q;  rr_d = rr_q;
    data0_d = data0_q;  miss0_d = miss0_q;  vld0_d = 1'b0;
    data1_d = data1_q;  miss1_d = miss1_q;  vld1_d = 1'b0;
    tx_wr = 1'b0;  rx_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.tuple_ready_0) begin
          key_d = bus.tuple_data_0;  loc_d = hidx(bus.tuple_data_0);
          probe_cnt_d = '0;  rr_d = 1'b1;  state_d = ST_TX_PROBE;
        end else if (bus.tuple_ready_1) begin
          key_d = bus.tuple_data_1;  loc_d = hidx(bus.tuple_data_1);
          probe_cnt_d = '0;  rr_d = 1'b0;  state_d = ST_RX_PROBE;
        end
      end
      ST_TX_PROBE: begin
        if (tx_hit) begin
          vld0_d = 1'b1;  miss0_d = 1'b0;  data0_d = 16'(tx_val);  state_d = ST_IDLE;
        end else if (!tx_vld && !full) begin
          tx_wr = 1'b1;  vld0_d = 1'b1;  miss0_d = 1'b0;  data0_d = 16'(next_id_q);
          loc_d = hidx(rx_key);  state_d = ST_RX_INS;
        end else if (!tx_vld || probe_cnt_q == PROBE_LAST) begin
          vld0_d = 1'b1;  miss0_d = 1'b1;  data0_d = '0;  state_d = ST_IDLE;
        end else begin
          loc_d = loc_q + 1'b1;  probe_cnt_d = probe_cnt_q + 1'b1;
        end
      end
      ST_RX_INS: begin
        // Always terminates: the rx table holds fewer than DEPTH entries here.
        if (!rx_vld) begin
          rx_wr = 1'b1;  next_id_d = next_id_q + 1'b1;
          conn_count_d = conn_count_q + 1'b1;  state_d = ST_IDLE;
        end else begin
          loc_d = loc_q + 1'b1;
        end
      end
      default: begin
        if (rx_hit) begin
          vld1_d = 1'b1;  miss1_d = 1'b0;  data1_d = rx_val;  state_d = ST_IDLE;
        end else if (!rx_vld || probe_cnt_q == PROBE_LAST) begin
          vld1_d = 1'b1;  miss1_d = 1'b1;  data1_d = '0;  state_d = ST_IDLE;
        end else begin
          loc_d = loc_q + 1'b1;  probe_cnt_d = probe_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;  key_q <= '0;  loc_q <= '0;  probe_cnt_q <= '0;
      next_id_q <= '0;  conn_count_q <= '0;  rr_q <= 1'b0;
      data0_q <= '0;  miss0_q <= 1'b0;  vld0_q <= 1'b0;
      data1_q <= '0;  miss1_q <= 1'b0;  vld1_q <= 1'b0;
    end else begin
      state_q <= state_d;  key_q <= key_d;  loc_q <= loc_d;  probe_cnt_q <= probe_cnt_d;
      next_id_q <= next_id_d;  conn_count_q <= conn_count_d;  rr_q <= rr_d;
      data0_q <= data0_d;  miss0_q <= miss0_d;  vld0_q <= vld0_d;
      data1_q <= data1_d;  miss1_q <= miss1_d;  vld1_q <= vld1_d;
    end
  end

  assign bus.conn_data_0  = data0_q;
  assign bus.conn_valid_0 = vld0_q;
  assign bus.conn_miss_0  = miss0_q;
  assign bus.conn_data_1  = data1_q;
  assign bus.conn_valid_1 = vld1_q;
  assign bus.conn_miss_1  = miss1_q;
  assign bus.table_full   = full;
  assign bus.conn_count   = conn_count_q;
endmodule

// File: tb/tb_nat_conn_table.sv
// Directed bench for nat_conn_table with a 16-slot table; expected values are hand-computed hashes.
module tb_nat_conn_table;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  nat_conn_table_if #(.HASH_LEN(4), .TUPLE_W(104)) bus ();

  nat_conn_table #(.HASH_LEN(4), .TUPLE_W(104), .MAX_PROBE(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [103:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [15:0] p, input logic [15:0] q,
                                      input logic [7:0] pr);
    return {a, b, p, q, pr};
  endfunction

  task automatic req(input int ch, input logic [103:0] t, output int lat,
                     output logic [15:0] d, output logic m);
    int n;
    @(negedge clk);
    if (ch == 0) begin bus.tuple_data_0 = t; bus.tuple_valid_0 = 1'b1; end
    else         begin bus.tuple_data_1 = t; bus.tuple_valid_1 = 1'b1; end
    #1;
    n = 0;
    while (((ch == 0) ? !bus.tuple_ready_0 : !bus.tuple_ready_1) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.tuple_valid_0 = 1'b0;
    bus.tuple_valid_1 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); #1; lat++;
    end while (!((ch == 0) ? bus.conn_valid_0 : bus.conn_valid_1) && lat < 100);
    if (lat >= 100) lat = -1;
    d = (ch == 0) ? bus.conn_data_0 : bus.conn_data_1;
    m = (ch == 0) ? bus.conn_miss_0 : bus.conn_miss_1;
  endtask

  // exp_lat < 0 skips the latency comparison (probe length depends on fill order).
  task automatic chk_req(input string tag, input int ch, input logic [103:0] t,
                         input int exp_lat, input logic [15:0] exp_d, input logic exp_m);
    int lat;
    logic [15:0] d;
    logic m;
    req(ch, t, lat, d, m);
    if (exp_lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(d), 32'(exp_d));
    check({tag, "_miss"}, 32'(m), 32'(exp_m));
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_vld0"},  32'(bus.conn_valid_0), 0);
    check({tag, "_miss0"}, 32'(bus.conn_miss_0),  0);
    check({tag, "_data0"}, 32'(bus.conn_data_0),  0);
    check({tag, "_vld1"},  32'(bus.conn_valid_1), 0);
    check({tag, "_miss1"}, 32'(bus.conn_miss_1),  0);
    check({tag, "_data1"}, 32'(bus.conn_data_1),  0);
    check({tag, "_count"}, 32'(bus.conn_count),   0);
    check({tag, "_full"},  32'(bus.table_full),   0);
  endtask

  logic [103:0] t1, t2, t_new, r1, r2, r_miss, r_ff;
  int grants[$];
  logic busy_prev, g0, g1;
  int seen;

  initial begin
    t1     = mk(32'h0A000001, 32'h08080808, 16'h1234, 16'h0050, 8'h06);
    t2     = mk(32'h0A000001, 32'h08080808, 16'h1235, 16'h0051, 8'h06);
    t_new  = mk(32'h0A000001, 32'h08080808, 16'h3000, 16'h0050, 8'h06);
    r1     = mk(32'h08080808, 32'h0A000001, 16'h0050, 16'h0000, 8'h06);
    r2     = mk(32'h08080808, 32'h0A000001, 16'h0051, 16'h0001, 8'h06);
    r_miss = mk(32'h08080808, 32'h0A000001, 16'h0050, 16'h0005, 8'h06);
    r_ff   = mk(32'h08080808, 32'h0A000001, 16'h0050, 16'h00FF, 8'h06);
    bus.tuple_data_0 = '0; bus.tuple_valid_0 = 1'b0;
    bus.tuple_data_1 = '0; bus.tuple_valid_1 = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_rdy0", 32'(bus.tuple_ready_0), 0);

    // First allocation: hash slot 11, ID 0.
    chk_req("tx_t1", 0, t1, 2, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check("cnt_after_t1", 32'(bus.conn_count), 1);
    chk_req("tx_t1_again", 0, t1, 2, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check("cnt_after_repeat", 32'(bus.conn_count), 1);
    chk_req("rx_r1", 1, r1, 2, 16'h1234, 1'b0);

    // t2 collides with t1 in tx (slot 11 -> 12); its rx key collides at 15 and wraps to 0.
    chk_req("tx_t2", 0, t2, 3, 16'h0001, 1'b0);
    repeat (5) @(negedge clk);
    check("cnt_after_t2", 32'(bus.conn_count), 2);
    chk_req("rx_r2", 1, r2, 3, 16'h1235, 1'b0);
    chk_req("rx_r1_b", 1, r1, 2, 16'h1234, 1'b0);
    chk_req("rx_empty_miss", 1, r_miss, 2, 16'h0000, 1'b1);

    for (int i = 0; i < 14; i++)
      chk_req("fill", 0, mk(32'h0A000001, 32'h08080808, 16'h2000 + 16'(i), 16'h0050, 8'h06),
              -1, 16'(i + 2), 1'b0);
    repeat (20) @(negedge clk);
    check("cnt_full", 32'(bus.conn_count), 16);
    check("full_flag", 32'(bus.table_full), 1);
    chk_req("tx_full_miss", 0, t_new, 17, 16'h0000, 1'b1);
    check("cnt_after_miss", 32'(bus.conn_count), 16);
    chk_req("tx_t1_full", 0, t1, 2, 16'h0000, 1'b0);
    chk_req("rx_fill5", 1, mk(32'h08080808, 32'h0A000001, 16'h0050, 16'h0007, 8'h06),
            -1, 16'h2005, 1'b0);
    chk_req("rx_limit_miss", 1, r_ff, 17, 16'h0000, 1'b1);

    // Both channels requesting every cycle: last served was rx, so tx goes first.
    @(negedge clk);
    bus.tuple_data_0 = t1; bus.tuple_data_1 = r1;
    bus.tuple_valid_0 = 1'b1; bus.tuple_valid_1 = 1'b1;
    busy_prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      g0 = bus.tuple_ready_0;
      g1 = bus.tuple_ready_1;
      check("arb_onehot", 32'(g0 & g1), 0);
      if (busy_prev) check("arb_busy_rdy", 32'({g0, g1}), 0);
      if (g0) grants.push_back(0);
      else if (g1) grants.push_back(1);
      busy_prev = g0 | g1;
      @(negedge clk);
    end
    bus.tuple_valid_0 = 1'b0; bus.tuple_valid_1 = 1'b0;
    check("arb_ngrants", 32'(grants.size()), 6);
    for (int i = 0; i < 4; i++)
      check("arb_order", (i < grants.size()) ? 32'(grants[i]) : 32'hFF, 32'(i % 2));
    repeat (4) @(negedge clk);

    // Reset in the middle of a 16-probe tx miss.
    @(negedge clk);
    bus.tuple_data_0 = t_new; bus.tuple_valid_0 = 1'b1;
    #1;
    check("mid_rdy", 32'(bus.tuple_ready_0), 1);
    @(posedge clk); #1;
    bus.tuple_valid_0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.conn_valid_0 || bus.conn_valid_1) seen++;
    end
    check("midrst_no_resp", 32'(seen), 0);
    chk_req("post_rst_t2", 0, t2, 2, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check("post_rst_cnt", 32'(bus.conn_count), 1);
    chk_req("post_rst_r1", 1, r1, 2, 16'h0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nat_conn_table.md
Name: nat_conn_table

Overview:
- Parametrised NAT connection table with two request channels:
  - Channel 0 (tx): look up or allocate a connection ID for an outbound 5-tuple.
  - Channel 1 (rx): map an inbound 5-tuple back to the original inner port.
- Linear-probed hash tables with explicit valid bits, a bounded probe length, miss reporting, a full flag and round-robin arbitration.
- Sits between the tuple extractor and the header rewriter in the NAT datapath.

Parameters:
- HASH_LEN, 6, index width; DEPTH = 2**HASH_LEN slots per table; legal range 4..8.
- TUPLE_W, 104, key/tuple width.
- MAX_PROBE, DEPTH, maximum slots probed per request before reporting a miss; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tuple_data_0  in  TUPLE_W  tx tuple: [7:0] proto, [23:8] outer_port, [39:24] inner_port, [71:40] outer_ip, [103:72] inner_ip.
- tuple_valid_0  in  1  tx request valid.
- tuple_ready_0  out  1  tx request accepted when valid && ready.
- conn_data_0  out  16  connection ID, zero-extended from HASH_LEN bits.
- conn_valid_0  out  1  one-cycle tx response strobe.
- conn_miss_0  out  1  qualifies conn_valid_0: no ID (table full or probe limit).
- tuple_data_1  in  TUPLE_W  rx tuple: [7:0] proto, [23:8] nat_port, [39:24] outer_port, [71:40] inner_ip, [103:72] outer_ip.
- tuple_valid_1  in  1  rx request valid.
- tuple_ready_1  out  1  rx request accepted when valid && ready.
- conn_data_1  out  16  original inner_port.
- conn_valid_1  out  1  one-cycle rx response strobe.
- conn_miss_1  out  1  qualifies conn_valid_1: no matching entry.
- table_full  out  1  conn_count == DEPTH.
- conn_count  out  HASH_LEN+1  number of allocated connections.

Behaviour:
- Reset: clears state to IDLE, all valid bits, next_id, conn_count, rr pointer, and every output.
  - Reset mid-request drops the request with no response.
  - Table data arrays are not reset; valid bits alone gate matches.
- Hash h(k): XOR of the low HASH_LEN bits of bits [7:0], [23:8], [39:24], [71:40] and [103:72].
  - The fold is field-order independent, so an rx key built with conn_id in the port slot hashes identically at insert and at lookup.
- Ready signals are combinational: tuple_ready_x = (state == IDLE) && grant_x.
  - Grant goes to the only valid channel. If both are valid, it goes to the channel not served last (rr pointer; channel 0 wins first after reset).
- States:
  - IDLE: on accept, latch the key, set loc = h(key) and probe_cnt = 0, then go to TX_PROBE or RX_PROBE.
  - TX_PROBE, each cycle on slot loc:
    - Valid and key match: respond ID = tx_id[loc], miss=0, go to IDLE.
    - Slot empty and !table_full: write key, set valid, tx_id[loc] = next_id, respond ID = next_id, miss=0, go to RX_INS with loc = h(rx key {inner_ip, outer_ip, next_id, outer_port, proto}).
    - Slot empty and table_full, or probe_cnt == MAX_PROBE-1: respond miss=1, conn_data_0 = 0, go to IDLE.
    - Otherwise: loc + 1 (wraps mod DEPTH), probe_cnt + 1.
  - RX_INS: first invalid slot from loc receives the rx key and inner_port. Then next_id++, conn_count++, go to IDLE.
    - An empty slot is guaranteed because the rx table holds conn_count < DEPTH entries. No response is generated and the probe limit does not apply.
  - RX_PROBE:
    - Valid and match: respond conn_data_1 = stored inner_port, go to IDLE.
    - Invalid slot (no deletions exist) or probe limit reached: respond miss=1, conn_data_1 = 0.
- Latency: accept at cycle T; hit on first probe gives conn_valid at T+2; each extra probe adds 1 cycle. A tx allocation occupies RX_INS for at least 1 more cycle before the next accept.
- Responses are single-cycle pulses; data holds until the next response. There is no response backpressure.
- No simultaneous accepts: one request is in flight at a time.
- next_id never wraps, because allocation stops at DEPTH.

Decomposition:
- Package nat_pkg: tuple field offsets, tx/rx field-slice localparams, state encoding, and the hash function.
- Sub-module nat_probe_table: valid-bit array, key/value array and match compare, parametrised by key/value width, instantiated for tx and for rx.

Test Plan:
- Reset, then tx tuple {inner_ip=0A000001, outer_ip=08080808, inner_port=1234, outer_port=0050, proto=06} -> conn_valid_0 at T+2, ID 0, miss 0; conn_count=1.
- Repeat the same tx tuple -> ID 0, count unchanged. Rx tuple with the same IPs, nat_port=0000, outer_port=0050, proto=06 -> conn_data_1=1234, miss 0.
- Two tx tuples forced to the same hash -> second gets ID 1, resolved at T+3 (one extra probe); rx lookups for both return correct inner ports.
- Fill DEPTH distinct tuples -> table_full=1; a new tuple returns miss 0_1 (conn_miss_0=1, data 0); existing tuples still hit.
- Both valids held high continuously -> grants alternate 0,1,0,1; ready is low outside IDLE.
- Assert reset during TX_PROBE -> no response, all outputs 0, conn_count=0, previous entries no longer hit.
